// File: rtl/matrix_stream_out.sv
// rtl/matrix_stream_out.sv - snapshots an MxN matrix and streams it out one tagged element per handshake
module matrix_stream_out #(
  parameter int M = 3,
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              transpose,
  input  logic [M*N*W-1:0]                  mat_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W-1:0]                      out_data,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col,
  output logic                              out_first,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   mat_q [M*N];
  logic [RW-1:0]  row_q, row_nxt;
  logic [CW-1:0]  col_q, col_nxt;
  logic           tr_q;
  logic           capture;
  logic           fire;
  logic           last_row, last_col;

  assign last_row = (row_q == RW'(M - 1));
  assign last_col = (col_q == CW'(N - 1));
  assign fire     = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    col_nxt   = col_q;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SEND;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      SEND: begin
        if (fire) begin
          if (last_row && last_col) begin
            // Counters park at zero so idle outputs read as zero
            state_nxt = DONE;
            row_nxt   = '0;
            col_nxt   = '0;
          end else if (tr_q) begin
            if (last_row) begin
              row_nxt = '0;
              col_nxt = col_q + CW'(1);
            end else begin
              row_nxt = row_q + RW'(1);
            end
          end else begin
            if (last_col) begin
              col_nxt = '0;
              row_nxt = row_q + RW'(1);
            end else begin
              col_nxt = col_q + CW'(1);
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row_q <= '0;
      col_q <= '0;
      tr_q  <= 1'b0;
      for (int k = 0; k < M*N; k++) mat_q[k] <= '0;
    end else begin
      state <= state_nxt;
      row_q <= row_nxt;
      col_q <= col_nxt;
      if (capture) begin
        tr_q <= transpose;
        for (int k = 0; k < M*N; k++) mat_q[k] <= mat_in[k*W +: W];
      end
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_first = out_valid && (row_q == '0) && (col_q == '0);
  assign out_last  = out_valid && last_row && last_col;

  always_comb begin
    out_data = '0;
    for (int k = 0; k < M*N; k++) begin
      if (out_valid && (k == int'(row_q) * N + int'(col_q))) out_data = mat_q[k];
    end
  end

endmodule

// File: tb/tb_matrix_stream_out.sv
// tb/tb_matrix_stream_out.sv - randomized self-checking bench for matrix_stream_out (3x3, 1x1, 2x4)
module tb_matrix_stream_out;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 3x3 instance
  logic         start = 0, transpose = 0, out_ready = 0;
  logic [287:0] mat_in = '0;
  logic         out_valid, out_first, out_last, busy, done;
  logic [31:0]  out_data;
  logic [1:0]   out_row, out_col;

  matrix_stream_out #(.M(3), .N(3), .W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .transpose(transpose), .mat_in(mat_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
  );

  // 1x1 instance
  logic        a_start = 0, a_transpose = 0, a_out_ready = 0;
  logic [31:0] a_mat_in = '0;
  logic        a_out_valid, a_out_first, a_out_last, a_busy, a_done;
  logic [31:0] a_out_data;
  logic [0:0]  a_out_row, a_out_col;

  matrix_stream_out #(.M(1), .N(1), .W(32)) dut_1x1 (
    .clk(clk), .reset(reset), .start(a_start), .transpose(a_transpose), .mat_in(a_mat_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_row(a_out_row),
    .out_col(a_out_col), .out_first(a_out_first), .out_last(a_out_last), .busy(a_busy), .done(a_done)
  );

  // 2x4 instance
  logic         b_start = 0, b_transpose = 0, b_out_ready = 0;
  logic [255:0] b_mat_in = '0;
  logic         b_out_valid, b_out_first, b_out_last, b_busy, b_done;
  logic [31:0]  b_out_data;
  logic [0:0]   b_out_row;
  logic [1:0]   b_out_col;

  matrix_stream_out #(.M(2), .N(4), .W(32)) dut_2x4 (
    .clk(clk), .reset(reset), .start(b_start), .transpose(b_transpose), .mat_in(b_mat_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_row(b_out_row),
    .out_col(b_out_col), .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  // Reference: beat k of a 3x3 stream as {data,row,col,first,last}
  function automatic logic [37:0] exp3(input logic [287:0] mat, input bit tr, input int k);
    int i, j;
    logic [31:0] d;
    i = tr ? (k % 3) : (k / 3);
    j = tr ? (k / 3) : (k % 3);
    d = mat[(i*3 + j)*32 +: 32];
    return {d, 2'(i), 2'(j), (k == 0), (k == 8)};
  endfunction

  function automatic logic [287:0] seq_mat();
    logic [287:0] m;
    for (int e = 0; e < 9; e++) m[e*32 +: 32] = 32'((e + 1) * 32'h11);
    return m;
  endfunction

  function automatic logic [287:0] rand_mat();
    logic [287:0] m;
    for (int e = 0; e < 9; e++) m[e*32 +: 32] = $urandom;
    return m;
  endfunction

  // rmode: 0 ready held high, 1 fixed 1,0,0,1,0,1 pattern, 2 random
  task automatic run_3x3(input string name, input logic [287:0] mat, input bit tr, input int rmode,
                         input int chg, input int restart, input int rst_at);
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int cyc, k;
    bit r, stalled;
    logic [37:0] cur, held, ex;
    @(negedge clk);
    mat_in = mat; transpose = tr; start = 1; out_ready = 0;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL %s idle_before_start: got %b want 000", name, {out_valid, busy, done});
    end
    @(negedge clk);
    start = 0; transpose = ~tr;
    cyc = 1; k = 0; stalled = 0; held = '0;
    while (k < 9 && k != rst_at && cyc < 200) begin
      start = (cyc == restart);
      if (cyc == chg) mat_in = '1;
      case (rmode)
        0:       r = 1'b1;
        1:       r = pat[(cyc - 1) % 6];
        default: r = 1'(($urandom_range(0, 1)));
      endcase
      out_ready = r;
      cur = {out_data, out_row, out_col, out_first, out_last};
      n_cmp++;
      if ({out_valid, busy, done} !== 3'b110) begin
        n_err++; $display("FAIL %s valid_mid_stream cyc %0d: got %b want 110", name, cyc, {out_valid, busy, done});
      end
      if (stalled) begin
        n_cmp++;
        if (cur !== held) begin
          n_err++; $display("FAIL %s stall_stable cyc %0d: got %h want %h", name, cyc, cur, held);
        end
      end
      if (r) begin
        ex = exp3(mat, tr, k);
        n_cmp++;
        if (cur !== ex) begin
          n_err++; $display("FAIL %s beat %0d: got %h want %h", name, k, cur, ex);
        end
        k++; stalled = 0;
      end else begin
        stalled = 1; held = cur;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0; out_ready = 0;
    if (cyc >= 200) begin
      n_cmp++; n_err++; $display("FAIL %s timeout: got %0d beats want 9", name, k);
    end else if (rst_at >= 0 && k == rst_at) begin
      reset = 1;
      #1;
      n_cmp++;
      if ({out_valid, busy, done, out_first, out_last, out_data} !== '0) begin
        n_err++; $display("FAIL %s async_abort: got %b want 0", name, {out_valid, busy, done});
      end
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, busy, done} !== 3'b000) begin
        n_err++; $display("FAIL %s after_abort: got %b want 000", name, {out_valid, busy, done});
      end
    end else begin
      if (rmode == 0) begin
        n_cmp++;
        if (cyc !== 10) begin
          n_err++; $display("FAIL %s zero_bubble: got %0d cycles want 10", name, cyc);
        end
      end
      n_cmp++;
      if ({done, out_valid, busy} !== 3'b101) begin
        n_err++; $display("FAIL %s done_pulse: got %b want 101", name, {done, out_valid, busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({done, out_valid, busy} !== 3'b000) begin
        n_err++; $display("FAIL %s back_idle: got %b want 000", name, {done, out_valid, busy});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done, out_first, out_last, out_data, out_row, out_col} !== '0) begin
      n_err++; $display("FAIL reset_3x3: got %b%b%b data %h want 0", out_valid, busy, done, out_data);
    end
    n_cmp++;
    if ({a_out_valid, a_busy, a_done, a_out_first, a_out_last, a_out_data} !== '0) begin
      n_err++; $display("FAIL reset_1x1: got %b%b%b want 000", a_out_valid, a_busy, a_done);
    end
    n_cmp++;
    if ({b_out_valid, b_busy, b_done, b_out_first, b_out_last, b_out_data} !== '0) begin
      n_err++; $display("FAIL reset_2x4: got %b%b%b want 000", b_out_valid, b_busy, b_done);
    end
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_release: got %b want 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_row_major();    run_3x3("row_major", seq_mat(), 0, 0, -1, -1, -1); endtask
  task automatic test_transpose();    run_3x3("transpose", seq_mat(), 1, 0, -1, -1, -1); endtask
  task automatic test_backpressure(); run_3x3("backpressure", seq_mat(), 0, 1, -1, -1, -1); endtask

  task automatic test_snapshot_busy();
    run_3x3("snapshot_busy", rand_mat(), 0, 2, 2, 3, -1);
    run_3x3("start_after_done", rand_mat(), 1, 0, -1, -1, -1);
  endtask

  task automatic test_reset_mid();
    run_3x3("reset_mid", seq_mat(), 0, 0, -1, -1, 4);
    run_3x3("after_reset", seq_mat(), 0, 0, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) run_3x3("random", rand_mat(), 1'($urandom_range(0, 1)), 2, -1, -1, -1);
  endtask

  task automatic test_single();
    @(negedge clk);
    a_mat_in = 32'hDEADBEEF; a_start = 1; a_out_ready = 0;
    @(negedge clk);
    a_start = 0; a_mat_in = '0;
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({a_out_valid, a_out_data, a_out_row, a_out_col, a_out_first, a_out_last} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        n_err++; $display("FAIL single_beat %0d: got %b %h %b%b", s, a_out_valid, a_out_data, a_out_first, a_out_last);
      end
      a_out_ready = (s == 1);
      @(negedge clk);
    end
    a_out_ready = 0;
    n_cmp++;
    if ({a_done, a_out_valid, a_busy} !== 3'b101) begin
      n_err++; $display("FAIL single_done: got %b want 101", {a_done, a_out_valid, a_busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({a_done, a_out_valid, a_busy} !== 3'b000) begin
      n_err++; $display("FAIL single_idle: got %b want 000", {a_done, a_out_valid, a_busy});
    end
  endtask

  task automatic test_2x4_transpose();
    logic [255:0] m;
    logic [35:0] cur, ex;
    int k, cyc, i, j;
    bit r;
    for (int e = 0; e < 8; e++) m[e*32 +: 32] = $urandom;
    @(negedge clk);
    b_mat_in = m; b_transpose = 1; b_start = 1;
    @(negedge clk);
    b_start = 0; b_transpose = 0;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 200) begin
      r = 1'($urandom_range(0, 1));
      b_out_ready = r;
      if (r) begin
        i = k % 2; j = k / 2;
        ex = {m[(i*4 + j)*32 +: 32], 1'(i), 2'(j), (k == 0), (k == 7)};
        cur = {b_out_data, b_out_row, b_out_col, b_out_first, b_out_last};
        n_cmp++;
        if (!b_out_valid || cur !== ex) begin
          n_err++; $display("FAIL 2x4_beat %0d: got %b %h want %h", k, b_out_valid, cur, ex);
        end
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    b_out_ready = 0;
    n_cmp++;
    if (cyc >= 200 || {b_done, b_out_valid, b_busy} !== 3'b101) begin
      n_err++; $display("FAIL 2x4_done: got %b want 101", {b_done, b_out_valid, b_busy});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_row_major();
    test_transpose();
    test_backpressure();
    test_snapshot_busy();
    test_reset_mid();
    test_random();
    test_single();
    test_2x4_transpose();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
